// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio mixer.
//   TIA_LUT  : 32-entry TIA volume curve indexed by tia_vol0 + tia_vol1
//   acc_t    : signed mix accumulator type
//   SAT_MAX / SAT_MIN : 16-bit signed output range
//   saturate : clamps an accumulator value to 16 bits and flags clipping
package audio_pkg;

  localparam int ACC_W = 24;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = acc_t'(32767);
  localparam acc_t SAT_MIN = -acc_t'(32768);

  localparam logic [15:0] TIA_LUT [0:31] = '{
    16'h0000, 16'h0842, 16'h0FFF, 16'h1745, 16'h1E1D, 16'h2492, 16'h2AAA, 16'h306E,
    16'h35E4, 16'h3B13, 16'h3FFF, 16'h44AE, 16'h4924, 16'h4D64, 16'h5173, 16'h5554,
    16'h590A, 16'h5C97, 16'h5FFF, 16'h6343, 16'h6665, 16'h6968, 16'h6C4D, 16'h6F17,
    16'h71C6, 16'h745C, 16'h76DA, 16'h7942, 16'h7B95, 16'h7DD3, 16'h7FFF, 16'hFFFF
  };

  typedef struct packed {
    logic [15:0] value;
    logic        clip;
  } sat_t;

  function automatic sat_t saturate(input acc_t x);
    sat_t r;
    if (x > SAT_MAX) begin
      r.value = 16'h7FFF;
      r.clip  = 1'b1;
    end else if (x < SAT_MIN) begin
      r.value = 16'h8000;
      r.clip  = 1'b1;
    end else begin
      r.value = x[15:0];
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_dcblock.sv
// Single-channel DC blocking filter: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
// y_out is combinational from x_in and the stored history; history advances
// only on cycles where valid_in is high.
//   clk_sys, reset : clock and synchronous active-high reset (clears history)
//   valid_in, x_in : sample qualifier and input sample
//   valid_out, y_out : filtered sample, aligned with valid_in
module audio_dcblock #(
  parameter int ACC_W    = 24,
  parameter int DC_SHIFT = 10
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic signed [ACC_W-1:0] x_in,
  output logic                    valid_out,
  output logic signed [ACC_W-1:0] y_out
);

  logic signed [ACC_W-1:0] x_prev_q, x_prev_d;
  logic signed [ACC_W-1:0] y_prev_q, y_prev_d;
  logic signed [ACC_W-1:0] y_now;

  always_comb begin
    y_now    = x_in - x_prev_q + y_prev_q - (y_prev_q >>> DC_SHIFT);
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    if (valid_in) begin
      x_prev_d = x_in;
      y_prev_d = y_now;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
    end
  end

  assign valid_out = valid_in;
  assign y_out     = y_now;

endmodule

// File: rtl/audio_mixer.sv
// Stereo audio mixer: TIA volume lookup + POKEY + signed YM, optional DC
// blocking, 16-bit saturation with clip reporting.
// Optional feature macro: AUDIO_MIXER_DCBLOCK_EN (DC blocker in stage 3).
// Ports:
//   clk_sys, reset          : clock, synchronous active-high reset
//   ce_in                   : sample strobe; inputs captured when high
//   mute                    : zeroes the mix input of that sample
//   tia_vol0/1, pokey_in, ym_l, ym_r : audio sources
//   clr_clip                : clears clip_count (wins over a same-cycle clip)
//   audio_l, audio_r        : signed 16-bit outputs, held between samples
//   out_valid, clip         : one-cycle pulses for each new sample
//   clip_count              : saturating count of clipped samples
// Handshake: valid-only, no backpressure. A ce_in cycle enters stage 1 and
// its valid bit moves one stage every clock; out_valid pulses three clock
// edges after the ce_in cycle. Every ce_in produces exactly one out_valid.
module audio_mixer #(
  parameter int DC_SHIFT = 10,
  parameter int ACC_W    = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_in,
  input  logic        mute,
  input  logic [3:0]  tia_vol0,
  input  logic [3:0]  tia_vol1,
  input  logic [15:0] pokey_in,
  input  logic [15:0] ym_l,
  input  logic [15:0] ym_r,
  input  logic        clr_clip,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        out_valid,
  output logic        clip,
  output logic [7:0]  clip_count
);
  import audio_pkg::*;

  typedef logic signed [ACC_W-1:0] mix_t;

  if (DC_SHIFT < 1 || DC_SHIFT >= ACC_W) begin : g_bad_dc_shift
    $error("audio_mixer: DC_SHIFT out of range");
  end

  // Stage 1: capture
  logic               s1_valid_q;
  logic [14:0]        tia_s_q, tia_s_d, pk_s_q, pk_s_d;
  logic signed [15:0] ym_l_q, ym_l_d, ym_r_q, ym_r_d;
  logic               mute_q, mute_d;
  logic [4:0]         idx;
  logic [15:0]        lut_val;

  // Stage 2: sum
  logic s2_valid_q;
  mix_t x_l_q, x_l_d, x_r_q, x_r_d;

  // Stage 3: filter + saturate
  logic        out_valid_q;
  logic [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic        clip_q, clip_d;
  logic [7:0]  clip_count_q, clip_count_d;
  logic        y_valid;
  mix_t        y_l, y_r;
  sat_t        sat_l, sat_r;
  logic        clip_any;

  always_comb begin
    idx     = {1'b0, tia_vol0} + {1'b0, tia_vol1};
    lut_val = TIA_LUT[idx];
    tia_s_d = tia_s_q;
    pk_s_d  = pk_s_q;
    ym_l_d  = ym_l_q;
    ym_r_d  = ym_r_q;
    mute_d  = mute_q;
    if (ce_in) begin
      tia_s_d = lut_val[15:1];
      pk_s_d  = pokey_in[15:1];
      ym_l_d  = ym_l;
      ym_r_d  = ym_r;
      mute_d  = mute;
    end
  end

  always_comb begin
    x_l_d = x_l_q;
    x_r_d = x_r_q;
    if (s1_valid_q) begin
      if (mute_q) begin
        x_l_d = '0;
        x_r_d = '0;
      end else begin
        // Unsigned sources zero-extend; YM sign-extends.
        x_l_d = mix_t'(tia_s_q) + mix_t'(pk_s_q) + mix_t'(ym_l_q);
        x_r_d = mix_t'(tia_s_q) + mix_t'(pk_s_q) + mix_t'(ym_r_q);
      end
    end
  end

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic y_valid_l, y_valid_r;

  audio_dcblock #(.ACC_W(ACC_W), .DC_SHIFT(DC_SHIFT)) u_dc_l (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .valid_in (s2_valid_q),
    .x_in     (x_l_q),
    .valid_out(y_valid_l),
    .y_out    (y_l)
  );

  audio_dcblock #(.ACC_W(ACC_W), .DC_SHIFT(DC_SHIFT)) u_dc_r (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .valid_in (s2_valid_q),
    .x_in     (x_r_q),
    .valid_out(y_valid_r),
    .y_out    (y_r)
  );

  assign y_valid = y_valid_l & y_valid_r;
`else
  assign y_valid = s2_valid_q;
  assign y_l     = x_l_q;
  assign y_r     = x_r_q;
`endif

  always_comb begin
    sat_l        = saturate(acc_t'(y_l));
    sat_r        = saturate(acc_t'(y_r));
    clip_any     = y_valid & (sat_l.clip | sat_r.clip);
    audio_l_d    = audio_l_q;
    audio_r_d    = audio_r_q;
    clip_d       = clip_any;
    clip_count_d = clip_count_q;
    if (y_valid) begin
      audio_l_d = sat_l.value;
      audio_r_d = sat_r.value;
    end
    if (clr_clip) begin
      clip_count_d = '0;
    end else if (clip_any && clip_count_q != 8'hFF) begin
      clip_count_d = clip_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      tia_s_q      <= '0;
      pk_s_q       <= '0;
      ym_l_q       <= '0;
      ym_r_q       <= '0;
      mute_q       <= 1'b0;
      s2_valid_q   <= 1'b0;
      x_l_q        <= '0;
      x_r_q        <= '0;
      out_valid_q  <= 1'b0;
      audio_l_q    <= '0;
      audio_r_q    <= '0;
      clip_q       <= 1'b0;
      clip_count_q <= '0;
    end else begin
      s1_valid_q   <= ce_in;
      tia_s_q      <= tia_s_d;
      pk_s_q       <= pk_s_d;
      ym_l_q       <= ym_l_d;
      ym_r_q       <= ym_r_d;
      mute_q       <= mute_d;
      s2_valid_q   <= s1_valid_q;
      x_l_q        <= x_l_d;
      x_r_q        <= x_r_d;
      out_valid_q  <= y_valid;
      audio_l_q    <= audio_l_d;
      audio_r_q    <= audio_r_d;
      clip_q       <= clip_d;
      clip_count_q <= clip_count_d;
    end
  end

  assign audio_l    = audio_l_q;
  assign audio_r    = audio_r_q;
  assign out_valid  = out_valid_q;
  assign clip       = clip_q;
  assign clip_count = clip_count_q;

endmodule

// File: tb/tb_audio_mixer.sv
module tb_audio_mixer;

  localparam int W = 34; // {valid, clip, left[15:0], right[15:0]}
  localparam int DC_SHIFT = 10;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_in = 1'b0;
  logic        mute = 1'b0;
  logic [3:0]  tia_vol0 = '0, tia_vol1 = '0;
  logic [15:0] pokey_in = '0, ym_l = '0, ym_r = '0;
  logic        clr_clip = 1'b0;
  logic [15:0] audio_l, audio_r;
  logic        out_valid, clip;
  logic [7:0]  clip_count;

  int total = 0;
  int bad = 0;

  // Reference state
  int dc_xl = 0, dc_yl = 0, dc_xr = 0, dc_yr = 0;
  int exp_cnt = 0;
  logic [W-1:0] exp_q[$];

  logic [15:0] ref_lut [32] = '{
    16'h0000, 16'h0842, 16'h0FFF, 16'h1745, 16'h1E1D, 16'h2492, 16'h2AAA, 16'h306E,
    16'h35E4, 16'h3B13, 16'h3FFF, 16'h44AE, 16'h4924, 16'h4D64, 16'h5173, 16'h5554,
    16'h590A, 16'h5C97, 16'h5FFF, 16'h6343, 16'h6665, 16'h6968, 16'h6C4D, 16'h6F17,
    16'h71C6, 16'h745C, 16'h76DA, 16'h7942, 16'h7B95, 16'h7DD3, 16'h7FFF, 16'hFFFF
  };

  audio_mixer dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_in     (ce_in),
    .mute      (mute),
    .tia_vol0  (tia_vol0),
    .tia_vol1  (tia_vol1),
    .pokey_in  (pokey_in),
    .ym_l      (ym_l),
    .ym_r      (ym_r),
    .clr_clip  (clr_clip),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .out_valid (out_valid),
    .clip      (clip),
    .clip_count(clip_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic reset_model();
    dc_xl = 0; dc_yl = 0; dc_xr = 0; dc_yr = 0;
    exp_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic void clamp(input int v, output logic [15:0] o, output logic c);
    if (v > 32767) begin o = 16'h7FFF; c = 1'b1; end
    else if (v < -32768) begin o = 16'h8000; c = 1'b1; end
    else begin o = v[15:0]; c = 1'b0; end
  endfunction

  // Computes the expected output of one sample and advances the filter state.
  task automatic ref_sample(input logic [3:0] t0, input logic [3:0] t1,
                            input logic [15:0] pk, input logic [15:0] yl,
                            input logic [15:0] yr, input logic m,
                            output logic [15:0] el, output logic [15:0] er,
                            output logic ec);
    int tia, pks, xl, xr, vl, vr;
    logic cl, cr;
    tia = int'(ref_lut[int'(t0) + int'(t1)]) / 2;
    pks = int'(pk) / 2;
    xl  = m ? 0 : tia + pks + int'($signed(yl));
    xr  = m ? 0 : tia + pks + int'($signed(yr));
`ifdef AUDIO_MIXER_DCBLOCK_EN
    vl = xl - dc_xl + dc_yl - (dc_yl >>> DC_SHIFT);
    vr = xr - dc_xr + dc_yr - (dc_yr >>> DC_SHIFT);
    dc_xl = xl; dc_yl = vl; dc_xr = xr; dc_yr = vr;
`else
    vl = xl;
    vr = xr;
`endif
    clamp(vl, el, cl);
    clamp(vr, er, cr);
    ec = cl | cr;
  endtask

  // ---------------- driver ----------------
  // Presents one sample for a single ce_in cycle; returns after that edge.
  task automatic drive_sample(input logic [3:0] t0, input logic [3:0] t1,
                              input logic [15:0] pk, input logic [15:0] yl,
                              input logic [15:0] yr, input logic m);
    tia_vol0 = t0; tia_vol1 = t1; pokey_in = pk; ym_l = yl; ym_r = yr; mute = m;
    ce_in = 1'b1;
    tick();
    ce_in = 1'b0;
    mute = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    reset_model();
    total++; if (audio_l !== 16'h0) begin bad++; $display("FAIL reset_audio_l got=%h exp=0000", audio_l); end
    total++; if (audio_r !== 16'h0) begin bad++; $display("FAIL reset_audio_r got=%h exp=0000", audio_r); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip got=%b exp=0", clip); end
    total++; if (clip_count !== 8'h0) begin bad++; $display("FAIL reset_clip_count got=%0d exp=0", clip_count); end
  endtask

  task automatic test_reset_mid_pipeline();
    drive_sample(4'd15, 4'd15, 16'hFFFF, 16'h7FFF, 16'h7FFF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_model();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_out_valid cycle=%0d got=%b exp=0", i, out_valid); end
      tick();
    end
    total++; if (audio_l !== 16'h0 || audio_r !== 16'h0) begin bad++; $display("FAIL mid_reset_audio got=%h/%h exp=0000/0000", audio_l, audio_r); end
    total++; if (clip_count !== 8'h0) begin bad++; $display("FAIL mid_reset_clip_count got=%0d exp=0", clip_count); end
  endtask

  task automatic test_latency_lut();
    logic [15:0] el, er;
    logic ec;
    ref_sample(4'd3, 4'd2, 16'h0, 16'h0, 16'h0, 1'b0, el, er, ec);
`ifndef AUDIO_MIXER_DCBLOCK_EN
    el = 16'h1249; er = 16'h1249; ec = 1'b0;
`endif
    drive_sample(4'd3, 4'd2, 16'h0, 16'h0, 16'h0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early1 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early2 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
    total++; if (audio_l !== el || audio_r !== er) begin bad++; $display("FAIL lut_audio got=%h/%h exp=%h/%h", audio_l, audio_r, el, er); end
    total++; if (clip !== ec) begin bad++; $display("FAIL lut_clip got=%b exp=%b", clip, ec); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_pulse_width got=%b exp=0", out_valid); end
  endtask

  task automatic test_signed_ym();
    logic [15:0] el, er;
    logic ec;
    ref_sample(4'd0, 4'd0, 16'h2000, 16'hF000, 16'h0100, 1'b0, el, er, ec);
`ifndef AUDIO_MIXER_DCBLOCK_EN
    el = 16'h0000; er = 16'h1100;
`endif
    drive_sample(4'd0, 4'd0, 16'h2000, 16'hF000, 16'h0100, 1'b0);
    tick(); tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL signed_valid got=%b exp=1", out_valid); end
    total++; if (audio_l !== el) begin bad++; $display("FAIL signed_audio_l got=%h exp=%h", audio_l, el); end
    total++; if (audio_r !== er) begin bad++; $display("FAIL signed_audio_r got=%h exp=%h", audio_r, er); end
  endtask

  task automatic test_saturation();
    logic [15:0] el, er;
    logic ec;
    for (int i = 0; i < 300; i++) begin
      ref_sample(4'd15, 4'd15, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, el, er, ec);
      if (ec && exp_cnt < 255) exp_cnt++;
      drive_sample(4'd15, 4'd15, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0);
      tick(); tick();
      if (i == 0) begin
`ifndef AUDIO_MIXER_DCBLOCK_EN
        el = 16'h7FFF;
`endif
        total++; if (audio_l !== el) begin bad++; $display("FAIL sat_audio_l got=%h exp=%h", audio_l, el); end
        total++; if (clip !== ec) begin bad++; $display("FAIL sat_clip got=%b exp=%b", clip, ec); end
        total++; if (clip_count !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_count_first got=%0d exp=%0d", clip_count, exp_cnt); end
      end
    end
    total++; if (clip_count !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_count_hold got=%0d exp=%0d", clip_count, exp_cnt); end
    // clr_clip coincides with the edge that registers a clipping sample
    ref_sample(4'd15, 4'd15, 16'hFFFF, 16'h7FFF, 16'h7FFF, 1'b0, el, er, ec);
    drive_sample(4'd15, 4'd15, 16'hFFFF, 16'h7FFF, 16'h7FFF, 1'b0);
    tick();
    clr_clip = 1'b1;
    tick();
    clr_clip = 1'b0;
    exp_cnt = 0;
    total++; if (clip !== ec) begin bad++; $display("FAIL clr_same_cycle_clip got=%b exp=%b", clip, ec); end
    total++; if (clip_count !== 8'h0) begin bad++; $display("FAIL clr_same_cycle_count got=%0d exp=0", clip_count); end
  endtask

  task automatic test_mute_hold();
    logic [15:0] el, er;
    logic ec;
    ref_sample(4'd7, 4'd4, 16'h1234, 16'h0567, 16'hF89A, 1'b1, el, er, ec);
`ifndef AUDIO_MIXER_DCBLOCK_EN
    el = 16'h0000; er = 16'h0000;
`endif
    drive_sample(4'd7, 4'd4, 16'h1234, 16'h0567, 16'hF89A, 1'b1);
    tick(); tick();
    total++; if (audio_l !== el || audio_r !== er) begin bad++; $display("FAIL mute_audio got=%h/%h exp=%h/%h", audio_l, audio_r, el, er); end
    tia_vol0 = 4'd9; pokey_in = 16'h4444; ym_l = 16'h1111; ym_r = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || audio_l !== el || audio_r !== er) begin
        bad++; $display("FAIL hold cycle=%0d got=%b %h/%h exp=0 %h/%h", i, out_valid, audio_l, audio_r, el, er);
      end
    end
  endtask

  // Random stream with back-to-back strobes, gaps and occasional clr_clip.
  task automatic test_back_to_back();
    logic [15:0] el, er, last_l, last_r;
    logic ec, v, m, c;
    logic [3:0] t0, t1;
    logic [15:0] pk, yl, yr;
    logic [W-1:0] e;
    exp_q.delete();
    last_l = audio_l; last_r = audio_r;
    exp_q.push_back('0);
    exp_q.push_back('0);
    for (int i = 0; i < 300; i++) begin
      v  = (i < 297) && ($urandom_range(0, 9) < 7);
      t0 = 4'($urandom_range(0, 15)); t1 = 4'($urandom_range(0, 15));
      pk = 16'($urandom); yl = 16'($urandom); yr = 16'($urandom);
      m  = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 19) == 0);
      tia_vol0 = t0; tia_vol1 = t1; pokey_in = pk; ym_l = yl; ym_r = yr;
      mute = m; ce_in = v; clr_clip = c;
      el = '0; er = '0; ec = 1'b0;
      if (v) ref_sample(t0, t1, pk, yl, yr, m, el, er, ec);
      exp_q.push_back({v, ec, el, er});
      tick();
      e = exp_q.pop_front();
      if (c) exp_cnt = 0;
      else if (e[33] && e[32] && exp_cnt < 255) exp_cnt++;
      if (e[33]) begin last_l = e[31:16]; last_r = e[15:0]; end
      total++;
      if (out_valid !== e[33] || clip !== (e[33] & e[32]) || audio_l !== last_l || audio_r !== last_r) begin
        bad++;
        $display("FAIL b2b cycle=%0d got=v%b c%b %h/%h exp=v%b c%b %h/%h", i, out_valid, clip,
                 audio_l, audio_r, e[33], e[33] & e[32], last_l, last_r);
      end
      total++;
      if (clip_count !== 8'(exp_cnt)) begin bad++; $display("FAIL b2b_count cycle=%0d got=%0d exp=%0d", i, clip_count, exp_cnt); end
    end
    ce_in = 1'b0; mute = 1'b0; clr_clip = 1'b0;
    exp_q.delete();
  endtask

`ifdef AUDIO_MIXER_DCBLOCK_EN
  task automatic test_dc_block();
    logic [15:0] el, er, prev;
    logic ec;
    reset = 1'b1; tick(); reset = 1'b0; reset_model();
    for (int i = 0; i < 60; i++) begin
      ref_sample(4'd0, 4'd0, 16'h2000, 16'h0, 16'h0, 1'b0, el, er, ec);
      if (i == 0) el = 16'h1000;
      drive_sample(4'd0, 4'd0, 16'h2000, 16'h0, 16'h0, 1'b0);
      tick(); tick();
      total++; if (audio_l !== el) begin bad++; $display("FAIL dc_sample i=%0d got=%h exp=%h", i, audio_l, el); end
      if (i > 0) begin
        total++; if ($signed(audio_l) > $signed(prev)) begin bad++; $display("FAIL dc_monotonic i=%0d got=%h exp<=%h", i, audio_l, prev); end
      end
      prev = audio_l;
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_reset_mid_pipeline();
    test_latency_lut();
    tick();
    test_signed_ym();
    tick();
    test_saturation();
    tick(); tick(); tick();
    test_mute_hold();
    test_back_to_back();
`ifdef AUDIO_MIXER_DCBLOCK_EN
    tick(); tick(); tick();
    test_dc_block();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
